sd_cmd_sequencer: RTL

Issues one SD-card SPI-mode command per request and collects its R1 response, using spi_controller as the byte engine. Holds the 6-byte command frame in an internal buffer exposed through spi_controller's memory interface (address in, data_in out, data_out/wr in). Sequences a frame write, then single-byte reads until a valid R1 arrives or the NCR poll budget expires. Sits between the card-init/block-transfer FSM (above) and spi_controller (below).

---
 rtl/sd_pkg.sv | 44 ++++
 rtl/sd_cmd_sequencer_if.sv | 39 +++
 rtl/sd_crc7.sv | 31 +++
 rtl/sd_cmd_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD-card SPI-mode command sequencer.
//   - sd_seq_state_t : sequencer FSM state encoding
//   - SD command index constants used when choosing the fixed CRC byte
//   - fixed CRC/stop bytes, frame start bits, timeout R1 value
//   - crc7_update    : one-byte step of CRC7 (x^7 + x^3 + 1), MSB first
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_SEND = 3'd3,
    POLL      = 3'd4,
    WAIT_POLL = 3'd5,
    CHECK     = 3'd6,
    DONE      = 3'd7
  } sd_seq_state_t;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [7:0] CRC_CMD0    = 8'h95;
  localparam logic [7:0] CRC_CMD8    = 8'h87;
  localparam logic [7:0] CRC_DEFAULT = 8'h01;
  localparam logic [7:0] START_BITS  = 8'h40;
  localparam logic [7:0] R1_TIMEOUT  = 8'hFF;

  // Shift one byte, MSB first, through the CRC7 register.
  function automatic logic [6:0] crc7_update(input logic [6:0] crc,
                                             input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: bundles the command request/response handshake
// (towards the card-init / block-transfer FSM) and the spi_controller
// control + memory-port signals.
//   modport slave  : the sequencer's view
//   modport master : the surrounding logic's view (requester + spi_controller)
interface sd_cmd_sequencer_if #(parameter int ADDR_W = 3);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;
  logic              resp_valid;
  logic [7:0]        resp_r1;
  logic              resp_timeout;
  logic              busy;
  logic              spi_start;
  logic              spi_op;
  logic [ADDR_W-1:0] spi_size;
  logic [ADDR_W-1:0] spi_address;
  logic [7:0]        spi_data_in;
  logic [7:0]        spi_data_out;
  logic              spi_wr;
  logic              spi_done;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg,
    input  spi_address, spi_data_out, spi_wr, spi_done,
    output cmd_ready, resp_valid, resp_r1, resp_timeout, busy,
    output spi_start, spi_op, spi_size, spi_data_in
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg,
    output spi_address, spi_data_out, spi_wr, spi_done,
    input  cmd_ready, resp_valid, resp_r1, resp_timeout, busy,
    input  spi_start, spi_op, spi_size, spi_data_in
  );

endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: byte-serial CRC7 (x^7 + x^3 + 1, init 0) for SD command frames.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_clr        : restart the CRC at zero
//   i_en         : fold i_byte into the running CRC this cycle
//   i_byte       : next frame byte, MSB first
//   o_crc_next   : CRC including i_byte (combinational), so the caller can
//                  finalise the frame on the same cycle as the last byte
// Only instantiated when SD_CMD_CRC7_EN is defined.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [6:0] o_crc_next
);

  logic [6:0] r_crc;

  assign o_crc_next = crc7_update(r_crc, i_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_crc <= 7'd0;
    else if (i_clr) r_crc <= 7'd0;
    else if (i_en)  r_crc <= o_crc_next;
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD SPI-mode command per request and collects
// its R1 response, driving spi_controller as the byte engine.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sd_cmd_sequencer_if.slave
//              cmd_valid/cmd_ready/cmd_index/cmd_arg  - command request
//              resp_valid/resp_r1/resp_timeout        - response pulse
//              busy                                   - not idle
//              spi_start/spi_op/spi_size              - transfer control
//              spi_address/spi_data_in                - frame buffer read port
//              spi_data_out/spi_wr/spi_done           - received byte, done
// Parameters: NCR_MAX (R1 poll budget, 1..255), ADDR_W (buffer address width)
// Build option: SD_CMD_CRC7_EN computes the real CRC7 over the frame in a
// 5-cycle LOAD; otherwise byte 5 is a fixed per-command constant.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 8,
  parameter int ADDR_W  = 3
)
(
  input logic            clk,
  input logic            rst,
  sd_cmd_sequencer_if.slave bus
);

  sd_seq_state_t     r_state;
  logic [7:0]        r_frame [0:5];
  logic [7:0]        r_rx;
  logic [7:0]        r_cnt;
  logic [7:0]        r_resp_r1;
  logic              r_resp_timeout;
  logic              r_spi_op;
  logic [ADDR_W-1:0] r_spi_size;
  logic [7:0]        w_data_in;

`ifdef SD_CMD_CRC7_EN
  logic [2:0]        r_load_cnt;
  logic [7:0]        w_crc_byte;
  logic [6:0]        w_crc_next;

  // Byte being folded into the CRC on this LOAD cycle.
  always_comb begin
    w_crc_byte = 8'hFF;
    for (int i = 0; i < 5; i++)
      if (r_load_cnt == 3'(i)) w_crc_byte = r_frame[i];
  end

  sd_crc7 u_crc7 (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == IDLE),
    .i_en       (r_state == LOAD),
    .i_byte     (w_crc_byte),
    .o_crc_next (w_crc_next)
  );
`else
  logic [5:0]        r_idx;

  // Only the commands sent before CRC checking is disabled need a real CRC.
  function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
    case (idx)
      CMD0:    return CRC_CMD0;
      CMD8:    return CRC_CMD8;
      default: return CRC_DEFAULT;
    endcase
  endfunction
`endif

  // Buffer read port; addresses past the frame read as idle-line 0xFF.
  always_comb begin
    w_data_in = 8'hFF;
    for (int i = 0; i < 6; i++)
      if (bus.spi_address == ADDR_W'(i)) w_data_in = r_frame[i];
  end

  assign bus.spi_data_in  = w_data_in;
  assign bus.cmd_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.spi_start    = (r_state == SEND) || (r_state == POLL);
  assign bus.resp_valid   = (r_state == DONE);
  assign bus.spi_op       = r_spi_op;
  assign bus.spi_size     = r_spi_size;
  assign bus.resp_r1      = r_resp_r1;
  assign bus.resp_timeout = r_resp_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rx           <= 8'hFF;
      r_cnt          <= 8'd0;
      r_resp_r1      <= R1_TIMEOUT;
      r_resp_timeout <= 1'b0;
      r_spi_op       <= 1'b0;
      r_spi_size     <= '0;
      for (int i = 0; i < 6; i++) r_frame[i] <= 8'hFF;
`ifdef SD_CMD_CRC7_EN
      r_load_cnt     <= 3'd0;
`else
      r_idx          <= 6'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_frame[0] <= START_BITS | {2'b00, bus.cmd_index};
            r_frame[1] <= bus.cmd_arg[31:24];
            r_frame[2] <= bus.cmd_arg[23:16];
            r_frame[3] <= bus.cmd_arg[15:8];
            r_frame[4] <= bus.cmd_arg[7:0];
`ifdef SD_CMD_CRC7_EN
            r_load_cnt <= 3'd0;
`else
            r_idx      <= bus.cmd_index;
`endif
            r_state    <= LOAD;
          end
        end
        LOAD: begin
`ifdef SD_CMD_CRC7_EN
          // Last CRC byte: take the combinational result so byte 5 is
          // ready on the same edge that enters SEND.
          if (r_load_cnt == 3'd4) begin
            r_frame[5] <= {w_crc_next, 1'b1};
            r_spi_op   <= 1'b1;
            r_spi_size <= ADDR_W'(5);
            r_state    <= SEND;
          end else begin
            r_load_cnt <= r_load_cnt + 3'd1;
          end
`else
          r_frame[5] <= fixed_crc_byte(r_idx);
          r_spi_op   <= 1'b1;
          r_spi_size <= ADDR_W'(5);
          r_state    <= SEND;
`endif
        end
        SEND: r_state <= WAIT_SEND;
        WAIT_SEND: begin
          if (bus.spi_done) begin
            r_cnt      <= 8'd0;
            r_rx       <= 8'hFF;
            r_spi_op   <= 1'b0;
            r_spi_size <= '0;
            r_state    <= POLL;
          end
        end
        POLL: r_state <= WAIT_POLL;
        WAIT_POLL: begin
          if (bus.spi_wr) r_rx <= bus.spi_data_out;
          if (bus.spi_done) begin
            r_cnt   <= r_cnt + 8'd1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          // R1 always has bit 7 clear; 0xFF-style bytes mean the card is
          // still in its NCR gap.
          if (!r_rx[7]) begin
            r_resp_r1      <= r_rx;
            r_resp_timeout <= 1'b0;
            r_state        <= DONE;
          end else if (r_cnt == 8'(NCR_MAX)) begin
            r_resp_r1      <= R1_TIMEOUT;
            r_resp_timeout <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_rx    <= 8'hFF;
            r_state <= POLL;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
